// File: rtl/ebpf_div_seq_if.sv
// ebpf_div_seq_if: request/result handshake bundle for the eBPF sequential divider.
// master = ALU / requester side, slave = divider side.
interface ebpf_div_seq_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_mod;
  logic             in_alu32;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_dbz;

  modport master (
    output in_valid, in_a, in_b, in_mod, in_alu32, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_dbz
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mod, in_alu32, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_dbz
  );
endinterface

// File: rtl/ebpf_div_seq.sv
// ebpf_div_seq: radix-2 restoring iterative divider (DIV/MOD, ALU32/ALU64).
// Optional signed support is compiled in with `define EBPF_DIV_SIGNED_EN;
// without it in_signed is ignored and all operations are unsigned.
module ebpf_div_seq #(
  parameter int unsigned WIDTH = 64
) (
  input logic           clk,
  input logic           rst_n,
  ebpf_div_seq_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic             r_mod;
  logic             r_alu32;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_dbz;
`ifdef EBPF_DIV_SIGNED_EN
  logic             r_qneg;
  logic             r_rneg;
  logic             w_sa, w_sb;
  logic [WIDTH-1:0] w_a_neg, w_b_neg;
`endif

  logic [WIDTH-1:0] w_a_eff, w_b_eff, w_a_mag, w_b_mag, w_dvd_init;
  logic             w_bz;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx, w_quo_nx, w_res_raw, w_res_sgn, w_res;

  // Operand preparation: effective operands, magnitudes, dividend alignment
  always_comb begin
    w_a_eff = bus.in_alu32 ? WIDTH'(bus.in_a[31:0]) : bus.in_a;
    w_b_eff = bus.in_alu32 ? WIDTH'(bus.in_b[31:0]) : bus.in_b;
    w_bz    = (w_b_eff == '0);
`ifdef EBPF_DIV_SIGNED_EN
    w_sa    = bus.in_signed & (bus.in_alu32 ? bus.in_a[31] : bus.in_a[WIDTH-1]);
    w_sb    = bus.in_signed & (bus.in_alu32 ? bus.in_b[31] : bus.in_b[WIDTH-1]);
    w_a_neg = '0 - w_a_eff;
    w_b_neg = '0 - w_b_eff;
    w_a_mag = w_sa ? (bus.in_alu32 ? WIDTH'(w_a_neg[31:0]) : w_a_neg) : w_a_eff;
    w_b_mag = w_sb ? (bus.in_alu32 ? WIDTH'(w_b_neg[31:0]) : w_b_neg) : w_b_eff;
`else
    w_a_mag = w_a_eff;
    w_b_mag = w_b_eff;
`endif
    // ALU32 dividend is left-aligned so the next bit is always the MSB
    w_dvd_init = bus.in_alu32 ? (w_a_mag << (WIDTH - 32)) : w_a_mag;
  end

  // Restoring step and final result selection / sign correction
  always_comb begin
    w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
    w_ge     = (w_rem_sh >= {1'b0, r_div});
    w_rem_nx = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_div}) : w_rem_sh[WIDTH-1:0];
    // quotient bits shift into the dividend register as dividend bits leave
    w_quo_nx  = {r_dvd[WIDTH-2:0], w_ge};
    w_res_raw = r_mod ? w_rem_nx : w_quo_nx;
`ifdef EBPF_DIV_SIGNED_EN
    w_res_sgn = (r_mod ? r_rneg : r_qneg) ? ('0 - w_res_raw) : w_res_raw;
`else
    w_res_sgn = w_res_raw;
`endif
    w_res = r_alu32 ? WIDTH'(w_res_sgn[31:0]) : w_res_sgn;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // FSM next-state and handshake outputs
  always_comb begin
    w_state_nx    = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_state_nx = w_bz ? DONE : CALC;
      end
      CALC: if (r_cnt == '0) w_state_nx = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Datapath registers: operand latch, iteration, result capture on DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_mod      <= 1'b0;
      r_alu32    <= 1'b0;
      r_out_data <= '0;
      r_out_dbz  <= 1'b0;
`ifdef EBPF_DIV_SIGNED_EN
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_mod   <= bus.in_mod;
          r_alu32 <= bus.in_alu32;
          r_div   <= w_b_mag;
          r_dvd   <= w_dvd_init;
          r_rem   <= '0;
          r_cnt   <= bus.in_alu32 ? CW'(31) : CW'(WIDTH - 1);
`ifdef EBPF_DIV_SIGNED_EN
          r_qneg  <= w_sa ^ w_sb;
          r_rneg  <= w_sa;
`endif
          if (w_bz) begin
            r_out_data <= bus.in_mod ? w_a_eff : '0;
            r_out_dbz  <= 1'b1;
          end
        end
        CALC: begin
          r_rem <= w_rem_nx;
          r_dvd <= w_quo_nx;
          if (r_cnt == '0) begin
            r_out_data <= w_res;
            r_out_dbz  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_data = r_out_data;
  assign bus.out_dbz  = r_out_dbz;
endmodule

// File: tb/tb_ebpf_div_seq.sv
// tb_ebpf_div_seq: directed and randomized checks of ebpf_div_seq against an
// arithmetic reference model.
module tb_ebpf_div_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  ebpf_div_seq_if #(.WIDTH(64)) u_if ();

  ebpf_div_seq #(.WIDTH(64)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  // Reference: eBPF divide semantics computed with native SV arithmetic
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input bit mod, input bit alu32, input bit sgn,
                                output logic [63:0] res, output bit dbz);
    logic [63:0] ea, eb;
    int          sa32, sb32, q32, m32;
    longint      sa64, sb64, q64, m64;
    bit          s;
`ifdef EBPF_DIV_SIGNED_EN
    s = sgn;
`else
    s = 1'b0;
`endif
    ea  = alu32 ? {32'h0, a[31:0]} : a;
    eb  = alu32 ? {32'h0, b[31:0]} : b;
    dbz = (eb == 64'h0);
    if (dbz) begin
      res = mod ? ea : 64'h0;
    end else if (!s) begin
      res = mod ? (ea % eb) : (ea / eb);
    end else if (alu32) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      if (sa32 == 32'h8000_0000 && sb32 == -1) begin q32 = sa32; m32 = 0; end
      else begin q32 = sa32 / sb32; m32 = sa32 % sb32; end
      res = {32'h0, 32'(mod ? m32 : q32)};
    end else begin
      sa64 = a;
      sb64 = b;
      if (sa64 == 64'h8000_0000_0000_0000 && sb64 == -1) begin q64 = sa64; m64 = 0; end
      else begin q64 = sa64 / sb64; m64 = sa64 % sb64; end
      res = mod ? m64 : q64;
    end
  endfunction

  // Issue one operation, wait (bounded) for the result and check it
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input bit mod, input bit alu32, input bit sgn,
                        input logic [63:0] exp_data, input bit exp_dbz, input int exp_lat);
    int lat;
    @(negedge clk);
    check_eq({tag, ".in_ready"}, u_if.in_ready, 1'b1);
    u_if.in_a      = a;
    u_if.in_b      = b;
    u_if.in_mod    = mod;
    u_if.in_alu32  = alu32;
    u_if.in_signed = sgn;
    u_if.in_valid  = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    lat = 1;
    while (!u_if.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, ".latency"}, lat, exp_lat);
    check_eq({tag, ".data"}, u_if.out_data, exp_data);
    check_eq({tag, ".dbz"}, u_if.out_dbz, exp_dbz);
    if (u_if.out_ready) begin
      @(posedge clk); #1;
      check_eq({tag, ".idle_next"}, {u_if.in_ready, u_if.out_valid}, 2'b10);
    end
  endtask

  task automatic run_rand(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input bit mod, input bit alu32, input bit sgn);
    logic [63:0] er;
    bit          ed;
    model(a, b, mod, alu32, sgn, er, ed);
    run_op(tag, a, b, mod, alu32, sgn, er, ed, ed ? 1 : (alu32 ? 33 : 65));
  endtask

  initial begin
    logic [63:0] held;
    logic [63:0] ra, rb;
    int          sel;
    n_checks = 0;
    n_pass   = 0;
    u_if.in_valid  = 1'b0;
    u_if.in_a      = '0;
    u_if.in_b      = '0;
    u_if.in_mod    = 1'b0;
    u_if.in_alu32  = 1'b0;
    u_if.in_signed = 1'b0;
    u_if.out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    check_eq("reset.in_ready", u_if.in_ready, 1'b1);
    check_eq("reset.out_valid", u_if.out_valid, 1'b0);
    check_eq("reset.out_data", u_if.out_data, 64'h0);
    check_eq("reset.out_dbz", u_if.out_dbz, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("u64_div", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 1'b0, 65);
    run_op("u64_mod", 64'd100, 64'd7, 1'b1, 1'b0, 1'b0, 64'd2, 1'b0, 65);
    run_op("a32_junk_div", 64'hFFFF_FFFF_0000_0064, 64'h0000_0005_0000_0003, 1'b0, 1'b1, 1'b0,
           64'h21, 1'b0, 33);
    run_op("a32_junk_mod", 64'hFFFF_FFFF_0000_0064, 64'h0000_0005_0000_0003, 1'b1, 1'b1, 1'b0,
           64'h1, 1'b0, 33);
    run_op("dbz_div", 64'h1234, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1);
    run_op("dbz_mod", 64'h1234, 64'h0, 1'b1, 1'b0, 1'b0, 64'h1234, 1'b1, 1);
`ifdef EBPF_DIV_SIGNED_EN
    run_op("s32_div", 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b0, 1'b1, 1'b1,
           64'h0000_0000_FFFF_FFFD, 1'b0, 33);
    run_op("s32_mod", 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b1,
           64'h0000_0000_FFFF_FFFF, 1'b0, 33);
    run_op("s64_ovf_div", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1,
           64'h8000_0000_0000_0000, 1'b0, 65);
    run_op("s64_ovf_mod", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1,
           64'h0, 1'b0, 65);
`else
    run_op("nosign_s32_div", 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b0, 1'b1, 1'b1,
           64'h7FFF_FFFC, 1'b0, 33);
`endif

    // Backpressure: result held while out_ready is low
    u_if.out_ready = 1'b0;
    run_op("bp", 64'd1000, 64'd33, 1'b0, 1'b1, 1'b0, 64'd30, 1'b0, 33);
    held = u_if.out_data;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("bp.hold_data", u_if.out_data, held);
      check_eq("bp.hold_hs", {u_if.in_ready, u_if.out_valid}, 2'b01);
    end
    @(negedge clk);
    u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp.release_idle", {u_if.in_ready, u_if.out_valid}, 2'b10);
    run_op("bp.next", 64'd77, 64'd7, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 65);

    // Reset in the middle of CALC
    @(negedge clk);
    u_if.in_a     = 64'd100;
    u_if.in_b     = 64'd7;
    u_if.in_mod   = 1'b0;
    u_if.in_alu32 = 1'b0;
    u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst.in_ready", u_if.in_ready, 1'b1);
    check_eq("midrst.out_valid", u_if.out_valid, 1'b0);
    check_eq("midrst.out_data", u_if.out_data, 64'h0);
    check_eq("midrst.out_dbz", u_if.out_dbz, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("midrst.9div3", 64'd9, 64'd3, 1'b0, 1'b0, 1'b0, 64'd3, 1'b0, 65);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ra  = {$urandom, $urandom};
      sel = $urandom_range(0, 5);
      case (sel)
        0:       rb = 64'h0;
        1:       rb = 64'($urandom_range(1, 40));
        2:       rb = -64'($urandom_range(1, 40));
        3:       begin ra = 64'h8000_0000_8000_0000; rb = 64'hFFFF_FFFF_FFFF_FFFF; end
        4:       rb = {32'h0, $urandom};
        default: rb = {$urandom, $urandom};
      endcase
      run_rand($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ebpf_div_seq.md
# ebpf_div_seq

Multi-cycle, parametrised integer divider for the eBPF core ALU. It replaces the single-cycle combinational divide with a radix-2 restoring iterative datapath. Supported modes:
- 32-bit (ALU32) and full-width (ALU64) operation
- quotient (DIV) or remainder (MOD) result
- optional signed operation (SDIV/SMOD)
- eBPF divide-by-zero semantics

The block sits beside the ALU in the execute stage and stalls the core through a valid/ready handshake on each side.

## Interface
- `WIDTH`, default 64: full operand/result width. Must be even and ≥ 32.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operation request.
- `in_ready`  out  1: block can accept an operation.
- `in_a`  in  WIDTH: dividend.
- `in_b`  in  WIDTH: divisor.
- `in_mod`  in  1: 0 selects quotient, 1 selects remainder.
- `in_alu32`  in  1: operate on bits [31:0] only.
- `in_signed`  in  1: two's-complement operation (see Configuration).
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer takes the result.
- `out_data`  out  WIDTH: result.
- `out_dbz`  out  1: the divisor was zero for this result.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch the operands and mode. Then go to DONE if the effective divisor is 0, otherwise go to CALC with iteration counter = N-1.
  - N = 32 when `in_alu32`=1, otherwise WIDTH.
- **Effective operands**
  - ALU32: the low 32 bits; the upper bits are ignored.
  - Signed: take the magnitudes of a and b. Record the quotient sign (sa XOR sb) and the remainder sign (sa).
- **CALC**
  - One quotient bit per cycle.
  - Each cycle: remainder R = {R, next dividend bit}. If R ≥ |b|, then R −= |b| and the quotient bit is 1.
  - Exit to DONE when the counter reaches 0.
- **DONE**
  - `out_valid`=1.
  - The result is selected and sign-corrected when entering DONE. It is held stable until `out_valid`&&`out_ready`, then the FSM returns to IDLE.
- **Result rules**
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Signed overflow (MIN / −1) gives quotient MIN and remainder 0. This falls out of the magnitude datapath with no special case.
  - Divide by zero: DIV returns 0 and MOD returns the effective dividend unchanged; `out_dbz`=1.
  - ALU32 results are zero-extended to WIDTH, including signed results.
- `in_ready`=0 in CALC and DONE. Requests are not accepted in those states, so there is no overlap between operations.
- There is no abort input. Only `rst_n` cancels an operation in flight.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_dbz`=0; internal registers = 0.
- Reset during CALC or DONE discards the operation with no output. The first edge after deassertion sees IDLE.
- Normal latency: accept at edge E, then N CALC cycles, then `out_valid`=1 after edge E+N+1.
  - ALU32: 33 cycles.
  - ALU64 with WIDTH=64: 65 cycles.
- Divide-by-zero latency: `out_valid`=1 after edge E+1.
- Back-to-back operation: if `out_ready`=1 at the first DONE cycle, the FSM is in IDLE at the next edge. The next accept can occur one cycle later, so throughput is 1 op per N+2 cycles.
- `out_data` and `out_dbz` may change only on entry to DONE.

## Configuration
- Macro `EBPF_DIV_SIGNED_EN`.
- **Defined:** `in_signed` is honoured. The block adds sign capture, a two's-complement negate on the operands, and a negate on the result.
- **Undefined:** `in_signed` is ignored and every operation is unsigned. The negate logic is removed, and ports and latency are unchanged.

## Test plan
- ALU64 unsigned: a=100, b=7, mod=0 → 14 after 65 cycles; the same with mod=1 → 2.
- ALU32 with upper junk: a=0xFFFFFFFF_00000064, b=0x5_00000003 → quotient 0x21, remainder 0x1 (operands taken from bits [31:0] only), upper 32 bits of the result 0, 33-cycle latency.
- Divide by zero, ALU64: a=0x1234, b=0 → DIV returns 0 and MOD returns 0x1234, both with `out_dbz`=1 after 1 cycle.
- Signed, macro defined:
  - ALU32: −7 / 2 → 0x00000000FFFFFFFD; −7 % 2 → 0x00000000FFFFFFFF.
  - ALU64: MIN / −1 → 0x8000000000000000 with remainder 0.
  - Macro undefined: −7 / 2 in ALU32 returns 0x7FFFFFFC.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `out_data` stable and `in_ready`=0 throughout; assert `out_ready` → IDLE next edge; a new request is accepted on the following cycle.
- Reset mid-operation: assert `rst_n`=0 at CALC cycle 20 → all outputs reset immediately; after release, a new operation of 9/3 returns 3 with the normal latency.
